// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller: FSM state encoding and a
// width helper for the sample-phase counter.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SAMPLE_ST = 2'd1,
        CONVERT   = 2'd2,
        DONE_ST   = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sar_shift_reg.sv
// Successive-approximation register: partial result plus a one-hot trial bit
// that walks from MSB to LSB, one comparator decision per step.
module sar_shift_reg
    import sar_pkg::*;
#(
    parameter int unsigned NBITS = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             load,
    input  logic             step,
    input  logic             CMP,
    output logic [NBITS-1:0] res,
    output logic [NBITS-1:0] trial,
    output logic             last
);

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            res   <= '0;
            trial <= '0;
        end else if (load) begin
            res   <= '0;
            trial <= {1'b1, {(NBITS-1){1'b0}}};
        end else if (step) begin
            // Masking rather than branching lets an unknown CMP taint only this bit
            res   <= res | (trial & {NBITS{CMP}});
            trial <= trial >> 1;
        end
    end

    assign last = trial[0];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: sample phase, NBITS comparator-driven bit decisions,
// then a one-cycle DONE strobe with the result latched on DOUT.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned NBITS         = 8,
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input  logic             C,
    input  logic             R,
    input  logic             START,
    input  logic             CMP,
    output logic             SAMPLE,
    output logic [NBITS-1:0] DAC,
    output logic             BUSY,
    output logic             DONE,
    output logic [NBITS-1:0] DOUT
);

    localparam int unsigned CW = (clog2(SAMPLE_CYCLES) < 1) ? 1 : clog2(SAMPLE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SAMPLE_CYCLES - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             dac_en;
    logic             load;
    logic             step;
    logic [NBITS-1:0] res;
    logic [NBITS-1:0] trial;
    logic             last;

    assign load = (state == SAMPLE_ST) && (cnt == '0);
    assign step = (state == CONVERT);

    sar_shift_reg #(
        .NBITS(NBITS)
    ) u_shift (
        .C    (C),
        .R    (R),
        .load (load),
        .step (step),
        .CMP  (CMP),
        .res  (res),
        .trial(trial),
        .last (last)
    );

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state  <= IDLE;
            cnt    <= '0;
            SAMPLE <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            DOUT   <= '0;
            dac_en <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE, DONE_ST: begin
                    if (START) begin
                        state  <= SAMPLE_ST;
                        cnt    <= CNT_LOAD;
                        SAMPLE <= 1'b1;
                        BUSY   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SAMPLE_ST: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= CONVERT;
                        SAMPLE <= 1'b0;
                        dac_en <= 1'b1;
                    end
                end
                CONVERT: begin
                    if (last) begin
                        state  <= DONE_ST;
                        DOUT   <= res | (trial & {NBITS{CMP}});
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                        dac_en <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    SAMPLE <= 1'b0;
                    BUSY   <= 1'b0;
                    dac_en <= 1'b0;
                end
            endcase
        end
    end

    // Trial code is only presented while converting; zero otherwise
    assign DAC = dac_en ? (res | trial) : '0;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: ideal comparator model, table-driven
// and random conversions, plus hand-written reset, back-to-back and 4-bit cases.
module tb_sar_adc_ctrl;

    localparam int S8 = 2;
    localparam int N8 = 8;

    logic       C = 1'b0;
    logic       R;
    logic       START;
    logic       CMP;
    logic       SAMPLE;
    logic [7:0] DAC;
    logic       BUSY;
    logic       DONE;
    logic [7:0] DOUT;
    logic [7:0] vin;

    logic       START4;
    logic       CMP4;
    logic       SAMPLE4;
    logic [3:0] DAC4;
    logic       BUSY4;
    logic       DONE4;
    logic [3:0] DOUT4;
    logic [3:0] vin4;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_dout;
    time last_done_t;

    typedef struct {
        logic [7:0] vin;
        logic [7:0] exp_dout;
    } vec_t;
    vec_t vecs [7];

    always #5 C = ~C;

    assign CMP  = (vin >= DAC);
    assign CMP4 = (vin4 >= DAC4);

    sar_adc_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2)) dut (
        .C(C), .R(R), .START(START), .CMP(CMP), .SAMPLE(SAMPLE), .DAC(DAC),
        .BUSY(BUSY), .DONE(DONE), .DOUT(DOUT)
    );

    sar_adc_ctrl #(.NBITS(4), .SAMPLE_CYCLES(1)) dut4 (
        .C(C), .R(R), .START(START4), .CMP(CMP4), .SAMPLE(SAMPLE4), .DAC(DAC4),
        .BUSY(BUSY4), .DONE(DONE4), .DOUT(DOUT4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Binary search reference: after k decisions the kept bits are the top k bits of vin
    function automatic logic [7:0] model_dac(input int nb, input logic [7:0] v, input int k);
        int vi;
        vi = int'(v);
        return 8'(((vi >> (nb - k)) << (nb - k)) | (1 << (nb - 1 - k)));
    endfunction

    function automatic logic [31:0] pack8(input logic s, input logic b, input logic d,
                                          input logic [7:0] dac, input logic [7:0] dout);
        return {13'd0, s, b, d, dac, dout};
    endfunction

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Runs one conversion starting with START=1 before edge 0; returns just after the DONE edge
    task automatic run_conv(input logic [7:0] v, input logic [7:0] exp_dout, input bit hold,
                            input bit repulse, input string tag);
        logic [31:0] exp;
        vin   = v;
        START = 1'b1;
        tick();
        for (int e = 0; e <= S8 + N8; e++) begin
            if (e < S8)
                exp = pack8(1'b1, 1'b1, 1'b0, 8'h00, model_dout);
            else if (e < S8 + N8)
                exp = pack8(1'b0, 1'b1, 1'b0, model_dac(N8, v, e - S8), model_dout);
            else
                exp = pack8(1'b0, 1'b0, 1'b1, 8'h00, exp_dout);
            chk($sformatf("%s edge%0d {SAMPLE,BUSY,DONE,DAC,DOUT}", tag, e),
                pack8(SAMPLE, BUSY, DONE, DAC, DOUT), exp);
            if (e < S8 + N8) begin
                if (e == 0 && !hold) START = 1'b0;
                if (e == 3 && repulse) START = 1'b1;
                if (e == 4 && repulse && !hold) START = 1'b0;
                tick();
            end
        end
        model_dout  = exp_dout;
        last_done_t = $time;
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s idle%0d", tag, i), pack8(SAMPLE, BUSY, DONE, DAC, DOUT),
                pack8(1'b0, 1'b0, 1'b0, 8'h00, model_dout));
        end
    endtask

    initial begin
        time t_prev;
        logic [7:0] rv;

        vecs[0] = '{8'hA5, 8'hA5};
        vecs[1] = '{8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF};
        vecs[3] = '{8'h3C, 8'h3C};
        vecs[4] = '{8'h10, 8'h10};
        vecs[5] = '{8'h7F, 8'h7F};
        vecs[6] = '{8'h80, 8'h80};

        R = 1'b1; START = 1'b0; START4 = 1'b0; vin = 8'h00; vin4 = 4'h0;
        model_dout = 8'h00; last_done_t = 0;
        #12;
        chk("reset state", pack8(SAMPLE, BUSY, DONE, DAC, DOUT), 32'd0);
        chk("reset state 4b", {SAMPLE4, BUSY4, DONE4, DAC4, DOUT4}, 32'd0);
        R = 1'b0;
        tick();

        // Table-driven single conversions
        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].vin, vecs[i].exp_dout, 1'b0, 1'b0, $sformatf("vec%0d", i));
            idle_check(1, $sformatf("vec%0d", i));
        end

        // Back-to-back with START held: DONE strobes 11 cycles apart
        run_conv(8'h10, 8'h10, 1'b1, 1'b0, "b2b0");
        t_prev = last_done_t;
        run_conv(8'h7F, 8'h7F, 1'b1, 1'b0, "b2b1");
        chk("b2b spacing 1", 32'(last_done_t - t_prev), 32'd110);
        t_prev = last_done_t;
        run_conv(8'h80, 8'h80, 1'b0, 1'b0, "b2b2");
        chk("b2b spacing 2", 32'(last_done_t - t_prev), 32'd110);
        idle_check(1, "b2b");

        // START re-pulsed while busy must not queue a second conversion
        run_conv(8'h5A, 8'h5A, 1'b0, 1'b1, "repulse");
        idle_check(3, "repulse");

        // Asynchronous reset mid-conversion
        vin = 8'hC3;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset busy", {31'd0, BUSY}, 32'd1);
        #2 R = 1'b1;
        #1 chk("async reset clears", pack8(SAMPLE, BUSY, DONE, DAC, DOUT), 32'd0);
        #1 R = 1'b0;
        model_dout = 8'h00;
        idle_check(1, "post-reset");
        run_conv(8'h3C, 8'h3C, 1'b0, 1'b0, "after-reset");
        idle_check(1, "after-reset");

        // Random conversions against the ideal model
        for (int i = 0; i < 16; i++) begin
            rv = 8'($urandom_range(0, 255));
            run_conv(rv, rv, 1'b0, ($urandom_range(0, 1) == 1), $sformatf("rand%0d", i));
            idle_check(1, $sformatf("rand%0d", i));
        end

        // 4-bit, single sample cycle build
        vin4   = 4'h9;
        START4 = 1'b1;
        tick();
        START4 = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            chk($sformatf("4b edge%0d DONE", e), {31'd0, DONE4}, {31'd0, (e == 5)});
            chk($sformatf("4b edge%0d SAMPLE", e), {31'd0, SAMPLE4}, {31'd0, (e == 0)});
            if (e >= 1 && e <= 4)
                chk($sformatf("4b edge%0d DAC", e), {28'd0, DAC4},
                    {24'd0, model_dac(4, {4'h0, vin4}, e - 1)});
            if (e == 5) chk("4b DOUT", {28'd0, DOUT4}, 32'h9);
            if (e < 5) tick();
        end
        tick();
        chk("4b DONE one cycle", {31'd0, DONE4}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
